// File: rtl/sbqm_queue_manager_p.sv
// Single-bank queue manager: glitch-filtered entry/exit photocells, a
// saturating occupancy counter with registered flags and warning pulses,
// and a multi-cycle restoring divider that estimates the wait time.
//
// Sensor handshake: the in/out photocells are plain level inputs. A person
// is counted only after a low phase of at least MIN_LOW cycles followed by
// a high sample. That one-cycle EVENT state is the only thing the counter
// consumes, so no valid/ready pair is needed.
module sbqm_queue_manager_p #(
   parameter int CAP_W   = 3,
   parameter int TCNT_W  = 2,
   parameter int WT_UNIT = 3,
   parameter int WT_W    = 5,
   parameter int MIN_LOW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in,
   input  logic              out,
   input  logic [TCNT_W-1:0] tcount,
   output logic [CAP_W-1:0]  pcount,
   output logic [WT_W-1:0]   wtime,
   output logic              wtime_valid,
   output logic              empty,
   output logic              full,
   output logic              warn_full,
   output logic              warn_empty,
   output logic              tcount_err,
   output logic [1:0]        dbg_in_state,
   output logic [1:0]        dbg_out_state
);

   localparam int NUM_W  = CAP_W + TCNT_W + $clog2(WT_UNIT + 1);
   localparam int STEP_W = $clog2(NUM_W);
   localparam int CNT_W  = $clog2(MIN_LOW + 1);
   localparam logic [CAP_W-1:0] CAP_MAX = '1;
   localparam logic [NUM_W-1:0] WT_MAX  = NUM_W'((1 << WT_W) - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOW   = 2'd1,
      S_EVENT = 2'd2
   } sens_state_e;

   // index 0 = entry photocell, index 1 = exit photocell
   sens_state_e      sens_state_q [2];
   sens_state_e      sens_state_d [2];
   logic [CNT_W-1:0] low_cnt_q [2];
   logic [CNT_W-1:0] low_cnt_d [2];
   logic [1:0]       sens_raw;
   logic             ev_in, ev_out;

   logic [CAP_W-1:0] pcount_q, pcount_d;
   logic             empty_q, empty_d, full_q, full_d;
   logic             warn_full_q, warn_full_d, warn_empty_q, warn_empty_d;

   logic [CAP_W-1:0]  p_l_q, p_l_d;
   logic [TCNT_W-1:0] t_l_q, t_l_d;
   logic              busy_q, busy_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [NUM_W-1:0]  num_q, num_d;
   logic [TCNT_W-1:0] rem_q, rem_d;
   logic [NUM_W-2:0]  quo_q, quo_d;
   logic [WT_W-1:0]   wtime_q, wtime_d;
   logic              valid_q, valid_d;
   logic              tcount_err_q, tcount_err_d;

   logic              op_mismatch;
   logic [TCNT_W:0]   rem_shift;
   logic              fits;
   logic [TCNT_W-1:0] rem_next;
   logic [NUM_W-1:0]  quo_next;
   logic [WT_W-1:0]   wt_sat;
   logic [NUM_W-1:0]  num_load;

   assign sens_raw = {out, in};
   assign ev_in    = (sens_state_q[0] == S_EVENT);
   assign ev_out   = (sens_state_q[1] == S_EVENT);

   // Glitch filter: count low cycles, accept the pulse on its rising edge.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         sens_state_d[c] = sens_state_q[c];
         low_cnt_d[c]    = low_cnt_q[c];
         case (sens_state_q[c])
            S_IDLE: begin
               if (!sens_raw[c]) begin
                  sens_state_d[c] = S_LOW;
                  low_cnt_d[c]    = CNT_W'(1);
               end
            end
            S_LOW: begin
               if (!sens_raw[c]) begin
                  if (low_cnt_q[c] < CNT_W'(MIN_LOW)) low_cnt_d[c] = low_cnt_q[c] + CNT_W'(1);
               end else begin
                  sens_state_d[c] = (low_cnt_q[c] >= CNT_W'(MIN_LOW)) ? S_EVENT : S_IDLE;
                  low_cnt_d[c]    = '0;
               end
            end
            S_EVENT: begin
               if (!sens_raw[c]) begin
                  sens_state_d[c] = S_LOW;
                  low_cnt_d[c]    = CNT_W'(1);
               end else begin
                  sens_state_d[c] = S_IDLE;
                  low_cnt_d[c]    = '0;
               end
            end
            default: begin
               sens_state_d[c] = S_IDLE;
               low_cnt_d[c]    = '0;
            end
         endcase
      end
   end

   // Sensor state registers.
   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (!rst) begin
            sens_state_q[c] <= S_IDLE;
            low_cnt_q[c]    <= '0;
         end else begin
            sens_state_q[c] <= sens_state_d[c];
            low_cnt_q[c]    <= low_cnt_d[c];
         end
      end
   end

   // Occupancy update; flags come from the next count so they never lag.
   always_comb begin
      pcount_d     = pcount_q;
      warn_full_d  = 1'b0;
      warn_empty_d = 1'b0;
      if (ev_in && !ev_out) begin
         if (pcount_q == CAP_MAX) warn_full_d = 1'b1;
         else                     pcount_d    = pcount_q + CAP_W'(1);
      end else if (ev_out && !ev_in) begin
         if (pcount_q == '0) warn_empty_d = 1'b1;
         else                pcount_d     = pcount_q - CAP_W'(1);
      end
      empty_d = (pcount_d == '0);
      full_d  = (pcount_d == CAP_MAX);
   end

   // Occupancy and flag registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pcount_q     <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         warn_full_q  <= 1'b0;
         warn_empty_q <= 1'b0;
      end else begin
         pcount_q     <= pcount_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         warn_full_q  <= warn_full_d;
         warn_empty_q <= warn_empty_d;
      end
   end

   // Divider datapath: one restoring step, saturation and the load value.
   always_comb begin
      op_mismatch = (p_l_q != pcount_q) || (t_l_q != tcount);
      rem_shift   = {rem_q, num_q[NUM_W-1]};
      fits        = (rem_shift >= {1'b0, t_l_q});
      rem_next    = fits ? (rem_shift[TCNT_W-1:0] - t_l_q) : rem_shift[TCNT_W-1:0];
      quo_next    = {quo_q, fits};
      wt_sat      = (quo_next > WT_MAX) ? '1 : WT_W'(quo_next);
      num_load    = NUM_W'(WT_UNIT) * (NUM_W'(pcount_q) + NUM_W'(tcount) - NUM_W'(1));
   end

   // Divider control: zero tellers aborts, busy steps, idle reloads on mismatch.
   always_comb begin
      p_l_d        = p_l_q;
      t_l_d        = t_l_q;
      busy_d       = busy_q;
      step_d       = step_q;
      num_d        = num_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      wtime_d      = wtime_q;
      valid_d      = valid_q;
      tcount_err_d = (tcount == '0);
      if (tcount == '0) begin
         busy_d  = 1'b0;
         step_d  = '0;
         t_l_d   = '0;
         wtime_d = '0;
         valid_d = 1'b0;
      end else if (busy_q) begin
         num_d  = {num_q[NUM_W-2:0], 1'b0};
         rem_d  = rem_next;
         quo_d  = quo_next[NUM_W-2:0];
         step_d = step_q + STEP_W'(1);
         if (step_q == STEP_W'(NUM_W - 1)) begin
            busy_d  = 1'b0;
            step_d  = '0;
            wtime_d = (p_l_q == '0) ? '0 : wt_sat;
            valid_d = !op_mismatch;
         end
      end else if (op_mismatch) begin
         p_l_d   = pcount_q;
         t_l_d   = tcount;
         num_d   = num_load;
         rem_d   = '0;
         quo_d   = '0;
         step_d  = '0;
         busy_d  = 1'b1;
         valid_d = 1'b0;
      end
   end

   // Divider registers; reset drops any division in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         p_l_q        <= '0;
         t_l_q        <= TCNT_W'(1);
         busy_q       <= 1'b0;
         step_q       <= '0;
         num_q        <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         wtime_q      <= '0;
         valid_q      <= 1'b1;
         tcount_err_q <= 1'b0;
      end else begin
         p_l_q        <= p_l_d;
         t_l_q        <= t_l_d;
         busy_q       <= busy_d;
         step_q       <= step_d;
         num_q        <= num_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         wtime_q      <= wtime_d;
         valid_q      <= valid_d;
         tcount_err_q <= tcount_err_d;
      end
   end

   assign pcount        = pcount_q;
   assign empty         = empty_q;
   assign full          = full_q;
   assign warn_full     = warn_full_q;
   assign warn_empty    = warn_empty_q;
   assign wtime         = wtime_q;
   assign wtime_valid   = valid_q;
   assign tcount_err    = tcount_err_q;
   assign dbg_in_state  = sens_state_q[0];
   assign dbg_out_state = sens_state_q[1];

endmodule

// File: tb/tb_sbqm_queue_manager_p.sv
// Bench for sbqm_queue_manager_p: directed scenarios followed by random
// photocell/teller traffic, every cycle compared against a reference model
// built from low-run lengths, an occupancy integer and plain division.
module tb_sbqm_queue_manager_p;

   localparam int CAP_W   = 3;
   localparam int TCNT_W  = 2;
   localparam int WT_UNIT = 3;
   localparam int WT_W    = 5;
   localparam int MIN_LOW = 2;
   localparam int NUM_W   = CAP_W + TCNT_W + $clog2(WT_UNIT + 1);
   localparam int CAP     = (1 << CAP_W) - 1;
   localparam int WT_MAX  = (1 << WT_W) - 1;

   // clock / reset / stimulus signals
   logic              clk = 1'b0;
   logic              rst;
   logic              in_s;
   logic              out_s;
   logic [TCNT_W-1:0] tcount;
   logic [CAP_W-1:0]  pcount;
   logic [WT_W-1:0]   wtime;
   logic              wtime_valid, empty, full, warn_full, warn_empty, tcount_err;
   logic [1:0]        dbg_in_state, dbg_out_state;

   always #5 clk = ~clk;

   sbqm_queue_manager_p #(
      .CAP_W(CAP_W), .TCNT_W(TCNT_W), .WT_UNIT(WT_UNIT), .WT_W(WT_W), .MIN_LOW(MIN_LOW)
   ) dut (
      .clk(clk), .rst(rst), .in(in_s), .out(out_s), .tcount(tcount),
      .pcount(pcount), .wtime(wtime), .wtime_valid(wtime_valid),
      .empty(empty), .full(full), .warn_full(warn_full), .warn_empty(warn_empty),
      .tcount_err(tcount_err), .dbg_in_state(dbg_in_state), .dbg_out_state(dbg_out_state)
   );

   int n_vec = 0;
   int n_err = 0;
   int cur_t = 1;

   // reference model state
   int m_p, m_wtime, m_left, m_pl, m_tl;
   bit m_wf, m_we, m_err, m_valid, m_busy;
   int m_run [2];
   bit m_ev  [2];

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int wait_result(input int p, input int t);
      int q;
      if (p == 0) return 0;
      q = (WT_UNIT * (p + t - 1)) / t;
      return (q > WT_MAX) ? WT_MAX : q;
   endfunction

   // Advance the model by one rising edge using the inputs held across it.
   task automatic model_step();
      int  old_p;
      bit  lo [2];
      if (!rst) begin
         m_p = 0; m_wf = 0; m_we = 0; m_err = 0;
         m_wtime = 0; m_valid = 1; m_busy = 0; m_left = 0; m_pl = 0; m_tl = 1;
         for (int c = 0; c < 2; c++) begin m_run[c] = 0; m_ev[c] = 0; end
         return;
      end
      old_p = m_p;
      m_wf = 0; m_we = 0;
      if (m_ev[0] && !m_ev[1]) begin
         if (m_p == CAP) m_wf = 1; else m_p = m_p + 1;
      end else if (m_ev[1] && !m_ev[0]) begin
         if (m_p == 0) m_we = 1; else m_p = m_p - 1;
      end
      if (tcount == 0) begin
         m_busy = 0; m_tl = 0; m_wtime = 0; m_valid = 0;
      end else if (m_busy) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_busy  = 0;
            m_wtime = wait_result(m_pl, m_tl);
            m_valid = (m_pl == old_p) && (m_tl == int'(tcount));
         end
      end else if (m_pl != old_p || m_tl != int'(tcount)) begin
         m_pl = old_p; m_tl = int'(tcount);
         m_busy = 1; m_left = NUM_W; m_valid = 0;
      end
      m_err = (tcount == 0);
      lo[0] = !in_s;
      lo[1] = !out_s;
      for (int c = 0; c < 2; c++) begin
         m_ev[c] = !lo[c] && (m_run[c] >= MIN_LOW);
         if (lo[c]) m_run[c] = (m_run[c] < MIN_LOW) ? m_run[c] + 1 : MIN_LOW;
         else       m_run[c] = 0;
      end
   endtask

   task automatic compare_all();
      check_eq("pcount", pcount, m_p);
      check_eq("empty", empty, int'(m_p == 0));
      check_eq("full", full, int'(m_p == CAP));
      check_eq("warn_full", warn_full, m_wf);
      check_eq("warn_empty", warn_empty, m_we);
      check_eq("tcount_err", tcount_err, m_err);
      check_eq("wtime", wtime, m_wtime);
      check_eq("wtime_valid", wtime_valid, m_valid);
   endtask

   // driver: hold inputs across one rising edge, compare on the falling edge
   task automatic cyc(input bit r, input bit i, input bit o, input int t);
      rst    = r;
      in_s   = i;
      out_s  = o;
      tcount = TCNT_W'(t);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1, 1, 1, cur_t);
   endtask

   task automatic pulse(input bit use_in, input bit use_out, input int n_low, input int n_high);
      for (int k = 0; k < n_low; k++)  cyc(1, !use_in, !use_out, cur_t);
      for (int k = 0; k < n_high; k++) cyc(1, 1, 1, cur_t);
   endtask

   initial begin
      bit ri, ro;
      // reset state
      cur_t = 1;
      cyc(0, 1, 1, cur_t);
      cyc(0, 1, 1, cur_t);
      check_eq("rst_pcount", pcount, 0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_valid", wtime_valid, 1);
      check_eq("rst_wtime", wtime, 0);
      idle(2);

      // fill to capacity with one teller, eighth entry rejected
      for (int k = 0; k < 8; k++) pulse(1, 0, 2, 2);
      idle(20);
      check_eq("fill_pcount", pcount, 7);
      check_eq("fill_full", full, 1);
      check_eq("fill_wtime", wtime, 21);
      check_eq("fill_valid", wtime_valid, 1);

      // wait-time arithmetic at several occupancies / teller counts
      cur_t = 2;
      pulse(0, 1, 2, 2); pulse(0, 1, 2, 2);
      idle(20);
      check_eq("p5t2_wtime", wtime, 9);
      cur_t = 3;
      pulse(1, 0, 2, 2); pulse(1, 0, 2, 2);
      idle(20);
      check_eq("p7t3_wtime", wtime, 9);
      cur_t = 2;
      for (int k = 0; k < 3; k++) pulse(0, 1, 2, 2);
      idle(20);
      check_eq("p4t2_wtime", wtime, 7);
      // teller count changes while the divider is busy
      cur_t = 3;
      idle(4);
      cur_t = 1;
      idle(20);
      check_eq("midchg_wtime", wtime, 12);
      check_eq("midchg_valid", wtime_valid, 1);

      // glitch filter: one low cycle dropped, two low cycles counted
      pulse(1, 0, 1, 4);
      check_eq("glitch_pcount", pcount, 4);
      cyc(1, 0, 1, cur_t);
      cyc(1, 0, 1, cur_t);
      cyc(1, 1, 1, cur_t);
      check_eq("release_pcount", pcount, 4);
      cyc(1, 1, 1, cur_t);
      check_eq("after_release_pcount", pcount, 5);

      // simultaneous entry/exit and empty rejection
      pulse(0, 1, 2, 2); pulse(0, 1, 2, 2);
      pulse(1, 1, 2, 2);
      check_eq("both_p3", pcount, 3);
      for (int k = 0; k < 3; k++) pulse(0, 1, 3, 2);
      check_eq("drain_p0", pcount, 0);
      pulse(0, 1, 2, 2);
      pulse(1, 1, 2, 2);
      check_eq("both_p0", pcount, 0);
      for (int k = 0; k < 7; k++) pulse(1, 0, 2, 2);
      pulse(1, 1, 2, 2);
      check_eq("both_p7", pcount, 7);

      // zero tellers, then reset in the middle of a division
      cur_t = 0;
      idle(3);
      check_eq("t0_err", tcount_err, 1);
      check_eq("t0_wtime", wtime, 0);
      check_eq("t0_valid", wtime_valid, 0);
      cur_t = 2;
      idle(3);
      cur_t = 1;
      cyc(0, 1, 1, cur_t);
      check_eq("middiv_rst_pcount", pcount, 0);
      check_eq("middiv_rst_wtime", wtime, 0);
      check_eq("middiv_rst_valid", wtime_valid, 1);
      check_eq("middiv_rst_err", tcount_err, 0);
      idle(12);

      // random traffic
      ri = 1; ro = 1;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) < 3) ri = ~ri;
         if ($urandom_range(0, 9) < 3) ro = ~ro;
         if ($urandom_range(0, 39) == 0)
            cur_t = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
         if ($urandom_range(0, 299) == 0) begin
            cur_t = 1;
            cyc(0, ri, ro, cur_t);
         end else begin
            cyc(1, ri, ro, cur_t);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
